// File: rtl/sys_rst_sequencer.sv
// sys_rst_sequencer
//
// Power-up and recovery reset sequencer placed after the clock
// infrastructure. It waits for a filtered DCM lock, pulses the IDELAYCTRL
// reset, waits for the delay controller to report ready and stay ready, then
// releases the user-fabric reset. Lock loss or calibration loss restarts the
// sequence. Saturating event counters feed software status registers.
//
// Parameters:
//   LOCK_FILTER - consecutive synchronised lock cycles needed before sequencing
//   RST_HOLD    - cycles idelay_rst is held high per calibration attempt
//   RDY_TIMEOUT - cycles to wait for idelay_rdy before retrying
//   SETTLE      - cycles idelay_rdy must stay high before release
//   CNT_W       - width of the shared phase counter
//
// Ports:
//   sys_clk         - sole clock
//   rst             - asynchronous active-high reset
//   sys_clk_lock    - DCM lock (asynchronous, synchronised internally)
//   idelay_rdy      - IDELAYCTRL ready (asynchronous, synchronised internally)
//   idelay_rst      - IDELAYCTRL reset back to infrastructure
//   sys_rst         - user-fabric reset, active-high
//   ready           - sequence complete (inverse of sys_rst)
//   retry_count     - saturating count of calibration retries
//   lock_loss_count - saturating count of lock losses
module sys_rst_sequencer #(
    parameter int unsigned LOCK_FILTER = 8,
    parameter int unsigned RST_HOLD    = 16,
    parameter int unsigned RDY_TIMEOUT = 4096,
    parameter int unsigned SETTLE      = 256,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       sys_clk_lock,
    input  logic       idelay_rdy,
    output logic       idelay_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] retry_count,
    output logic [7:0] lock_loss_count
);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK,
        ST_IDLY_RST,
        ST_WAIT_RDY,
        ST_SETTLE,
        ST_RUN
    } state_t;

    localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(RDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE - 1);

    // Two-flop synchronisers for the asynchronous status inputs
    logic lock_meta_q, lock_s_q;
    logic rdy_meta_q,  rdy_s_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             idelay_rst_q, idelay_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic [7:0]       retry_count_q, retry_count_d;
    logic [7:0]       lock_loss_count_q, lock_loss_count_d;

    logic retry_inc;
    logic loss_inc;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        retry_inc = 1'b0;
        loss_inc  = 1'b0;

        case (state_q)
            ST_WAIT_LOCK: begin
                if (!lock_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = ST_IDLY_RST;
                end
            end
            ST_IDLY_RST: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                // Ready arriving on the timeout cycle still wins
                if (rdy_s_q) begin
                    state_d = ST_SETTLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = ST_IDLY_RST;
                    retry_inc = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!rdy_s_q) begin
                    state_d   = ST_IDLY_RST;
                    retry_inc = 1'b1;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Counter is not needed while running; hold it to avoid wrap
                cnt_d = cnt_q;
                if (!rdy_s_q) begin
                    state_d   = ST_IDLY_RST;
                    retry_inc = 1'b1;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
            end
        endcase

        // Lock loss overrides any calibration event on the same cycle
        if (state_q != ST_WAIT_LOCK && !lock_s_q) begin
            state_d   = ST_WAIT_LOCK;
            loss_inc  = 1'b1;
            retry_inc = 1'b0;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        retry_count_d = retry_count_q;
        if (retry_inc && retry_count_q != 8'hFF) begin
            retry_count_d = retry_count_q + 8'd1;
        end

        lock_loss_count_d = lock_loss_count_q;
        if (loss_inc && lock_loss_count_q != 8'hFF) begin
            lock_loss_count_d = lock_loss_count_q + 8'd1;
        end

        // Outputs decoded from the next state so they move with the state edge
        idelay_rst_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_IDLY_RST);
        sys_rst_d    = (state_d != ST_RUN);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            lock_meta_q       <= 1'b0;
            lock_s_q          <= 1'b0;
            rdy_meta_q        <= 1'b0;
            rdy_s_q           <= 1'b0;
            state_q           <= ST_WAIT_LOCK;
            cnt_q             <= '0;
            idelay_rst_q      <= 1'b1;
            sys_rst_q         <= 1'b1;
            retry_count_q     <= '0;
            lock_loss_count_q <= '0;
        end else begin
            lock_meta_q       <= sys_clk_lock;
            lock_s_q          <= lock_meta_q;
            rdy_meta_q        <= idelay_rdy;
            rdy_s_q           <= rdy_meta_q;
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            idelay_rst_q      <= idelay_rst_d;
            sys_rst_q         <= sys_rst_d;
            retry_count_q     <= retry_count_d;
            lock_loss_count_q <= lock_loss_count_d;
        end
    end

    assign idelay_rst      = idelay_rst_q;
    assign sys_rst         = sys_rst_q;
    assign ready           = ~sys_rst_q;
    assign retry_count     = retry_count_q;
    assign lock_loss_count = lock_loss_count_q;

endmodule

// File: tb/tb_sys_rst_sequencer.sv
// tb_sys_rst_sequencer
//
// Directed bench for sys_rst_sequencer with LOCK_FILTER=4, RST_HOLD=8,
// RDY_TIMEOUT=32, SETTLE=16. idelay_rdy follows a simple model: it rises
// 5 cycles after idelay_rst falls and drops while idelay_rst is high, unless
// disabled or forced low by a test.
module tb_sys_rst_sequencer;

    logic       sys_clk;
    logic       rst;
    logic       sys_clk_lock;
    logic       idelay_rdy;
    logic       idelay_rst;
    logic       sys_rst;
    logic       ready;
    logic [7:0] retry_count;
    logic [7:0] lock_loss_count;

    int errors = 0;
    int checks = 0;

    // rdy model state
    logic rdy_en;
    logic rdy_force_low;
    int   low_cyc;

    sys_rst_sequencer #(
        .LOCK_FILTER (4),
        .RST_HOLD    (8),
        .RDY_TIMEOUT (32),
        .SETTLE      (16),
        .CNT_W       (16)
    ) dut (
        .sys_clk         (sys_clk),
        .rst             (rst),
        .sys_clk_lock    (sys_clk_lock),
        .idelay_rdy      (idelay_rdy),
        .idelay_rst      (idelay_rst),
        .sys_rst         (sys_rst),
        .ready           (ready),
        .retry_count     (retry_count),
        .lock_loss_count (lock_loss_count)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Advance one clock; inputs are updated 1 ns after the rising edge.
    task automatic step();
        @(posedge sys_clk);
        #1;
        if (idelay_rst) low_cyc = 0;
        else if (low_cyc < 1000) low_cyc = low_cyc + 1;
        idelay_rdy = rdy_en && !rdy_force_low && (low_cyc >= 6);
    endtask

    task automatic set_force(input logic v);
        rdy_force_low = v;
        idelay_rdy = rdy_en && !rdy_force_low && (low_cyc >= 6);
    endtask

    // Steps until idelay_rst equals val; n is the step count, -1 on timeout.
    task automatic wait_irst(input logic val, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (idelay_rst === val) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_srst(input logic val, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (sys_rst === val) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        sys_clk_lock = 1'b0;
        rdy_en = 1'b1;
        set_force(1'b0);
        repeat (3) step();
    endtask

    // Called right after a step: release reset with lock already present.
    task automatic release_with_lock();
        rst = 1'b0;
        sys_clk_lock = 1'b1;
    endtask

    task automatic bring_up();
        int n;
        wait_irst(1'b0, 64, n);
        wait_srst(1'b0, 64, n);
        checks++; if (sys_rst !== 1'b0) begin errors++; $display("FAIL bring_up_sys_rst: got %0b expected 0", sys_rst); end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (idelay_rst !== 1'b1) begin errors++; $display("FAIL reset_idelay_rst: got %0b expected 1", idelay_rst); end
        checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL reset_sys_rst: got %0b expected 1", sys_rst); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b expected 0", ready); end
        checks++; if (retry_count !== 8'd0) begin errors++; $display("FAIL reset_retry: got %0d expected 0", retry_count); end
        checks++; if (lock_loss_count !== 8'd0) begin errors++; $display("FAIL reset_loss: got %0d expected 0", lock_loss_count); end
    endtask

    task automatic test_clean_bringup();
        int n;
        apply_reset();
        release_with_lock();
        // 2 sync edges + 4 filter + 8 hold
        wait_irst(1'b0, 64, n);
        checks++; if (n !== 14) begin errors++; $display("FAIL clean_irst_fall: got %0d expected 14", n); end
        // 5 rdy delay + 2 sync + 1 WAIT_RDY + 16 settle
        wait_srst(1'b0, 64, n);
        checks++; if (n !== 24) begin errors++; $display("FAIL clean_srst_fall: got %0d expected 24", n); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL clean_ready: got %0b expected 1", ready); end
        checks++; if (idelay_rst !== 1'b0) begin errors++; $display("FAIL clean_irst_low: got %0b expected 0", idelay_rst); end
        checks++; if (retry_count !== 8'd0) begin errors++; $display("FAIL clean_retry: got %0d expected 0", retry_count); end
        checks++; if (lock_loss_count !== 8'd0) begin errors++; $display("FAIL clean_loss: got %0d expected 0", lock_loss_count); end
    endtask

    task automatic test_glitchy_lock();
        int n;
        apply_reset();
        release_with_lock();
        repeat (3) step();
        sys_clk_lock = 1'b0;
        step();
        sys_clk_lock = 1'b1;
        // Filter restarts: total fall at edge 18, 4 edges already consumed
        wait_irst(1'b0, 64, n);
        checks++; if (n !== 14) begin errors++; $display("FAIL glitch_irst_fall: got %0d expected 14", n); end
        wait_srst(1'b0, 64, n);
        checks++; if (n !== 24) begin errors++; $display("FAIL glitch_srst_fall: got %0d expected 24", n); end
        checks++; if (lock_loss_count !== 8'd0) begin errors++; $display("FAIL glitch_loss: got %0d expected 0", lock_loss_count); end
    endtask

    task automatic test_rdy_held_low();
        int n;
        int bad_hi;
        int bad_lo;
        int bad_srst;
        apply_reset();
        rdy_en = 1'b0;
        release_with_lock();
        wait_irst(1'b0, 64, n);
        checks++; if (n !== 14) begin errors++; $display("FAIL rdylow_first_fall: got %0d expected 14", n); end
        bad_hi = 0;
        bad_lo = 0;
        bad_srst = 0;
        for (int a = 1; a <= 257; a++) begin
            wait_irst(1'b1, 64, n);
            if (n != 32) bad_lo++;
            if (a == 1) begin
                checks++; if (retry_count !== 8'd1) begin errors++; $display("FAIL rdylow_retry_1: got %0d expected 1", retry_count); end
            end
            if (a == 255) begin
                checks++; if (retry_count !== 8'd255) begin errors++; $display("FAIL rdylow_retry_255: got %0d expected 255", retry_count); end
            end
            wait_irst(1'b0, 64, n);
            if (n != 8) bad_hi++;
            if (sys_rst !== 1'b1) bad_srst++;
        end
        checks++; if (bad_lo !== 0) begin errors++; $display("FAIL rdylow_wait_period: got %0d bad attempts expected 0", bad_lo); end
        checks++; if (bad_hi !== 0) begin errors++; $display("FAIL rdylow_pulse_width: got %0d bad pulses expected 0", bad_hi); end
        checks++; if (bad_srst !== 0) begin errors++; $display("FAIL rdylow_sys_rst: got %0d release samples expected 0", bad_srst); end
        checks++; if (retry_count !== 8'd255) begin errors++; $display("FAIL rdylow_retry_sat: got %0d expected 255", retry_count); end
        checks++; if (lock_loss_count !== 8'd0) begin errors++; $display("FAIL rdylow_loss: got %0d expected 0", lock_loss_count); end
        rdy_en = 1'b1;
    endtask

    task automatic test_rdy_drop();
        int n;
        apply_reset();
        release_with_lock();
        wait_irst(1'b0, 64, n);
        checks++; if (n !== 14) begin errors++; $display("FAIL rdydrop_irst_fall: got %0d expected 14", n); end
        // SETTLE entered 8 edges after the fall; drop rdy 4 edges into it
        repeat (12) step();
        set_force(1'b1);
        wait_irst(1'b1, 16, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL rdydrop_settle_rise: got %0d expected 3", n); end
        checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL rdydrop_settle_srst: got %0b expected 1", sys_rst); end
        checks++; if (retry_count !== 8'd1) begin errors++; $display("FAIL rdydrop_settle_retry: got %0d expected 1", retry_count); end
        set_force(1'b0);
        wait_irst(1'b0, 64, n);
        checks++; if (n !== 8) begin errors++; $display("FAIL rdydrop_settle_pulse: got %0d expected 8", n); end
        // Full 16-cycle settle again
        wait_srst(1'b0, 64, n);
        checks++; if (n !== 24) begin errors++; $display("FAIL rdydrop_settle_release: got %0d expected 24", n); end
        // Now drop rdy while running
        set_force(1'b1);
        wait_irst(1'b1, 16, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL rdydrop_run_rise: got %0d expected 3", n); end
        checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL rdydrop_run_srst: got %0b expected 1", sys_rst); end
        set_force(1'b0);
        checks++; if (retry_count !== 8'd2) begin errors++; $display("FAIL rdydrop_run_retry: got %0d expected 2", retry_count); end
        wait_irst(1'b0, 64, n);
        checks++; if (n !== 8) begin errors++; $display("FAIL rdydrop_run_pulse: got %0d expected 8", n); end
        wait_srst(1'b0, 64, n);
        checks++; if (n !== 24) begin errors++; $display("FAIL rdydrop_run_release: got %0d expected 24", n); end
        checks++; if (lock_loss_count !== 8'd0) begin errors++; $display("FAIL rdydrop_loss: got %0d expected 0", lock_loss_count); end
    endtask

    task automatic test_lock_drop_run();
        int n;
        apply_reset();
        release_with_lock();
        bring_up();
        // One raw cycle of lock loss
        sys_clk_lock = 1'b0;
        step();
        sys_clk_lock = 1'b1;
        checks++; if (sys_rst !== 1'b0) begin errors++; $display("FAIL lockdrop_edge1: got %0b expected 0", sys_rst); end
        step();
        checks++; if (sys_rst !== 1'b0) begin errors++; $display("FAIL lockdrop_edge2: got %0b expected 0", sys_rst); end
        step();
        checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL lockdrop_edge3_srst: got %0b expected 1", sys_rst); end
        checks++; if (idelay_rst !== 1'b1) begin errors++; $display("FAIL lockdrop_edge3_irst: got %0b expected 1", idelay_rst); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL lockdrop_ready: got %0b expected 0", ready); end
        checks++; if (lock_loss_count !== 8'd1) begin errors++; $display("FAIL lockdrop_loss: got %0d expected 1", lock_loss_count); end
        checks++; if (retry_count !== 8'd0) begin errors++; $display("FAIL lockdrop_retry: got %0d expected 0", retry_count); end
        // lock_s already back: 4 filter + 8 hold
        wait_irst(1'b0, 64, n);
        checks++; if (n !== 12) begin errors++; $display("FAIL lockdrop_reseq_fall: got %0d expected 12", n); end
        wait_srst(1'b0, 64, n);
        checks++; if (n !== 24) begin errors++; $display("FAIL lockdrop_reseq_release: got %0d expected 24", n); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL lockdrop_ready_back: got %0b expected 1", ready); end
        // Lock and rdy lost together: only a lock loss is counted
        sys_clk_lock = 1'b0;
        set_force(1'b1);
        step();
        sys_clk_lock = 1'b1;
        set_force(1'b0);
        step();
        step();
        checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL simul_srst: got %0b expected 1", sys_rst); end
        checks++; if (lock_loss_count !== 8'd2) begin errors++; $display("FAIL simul_loss: got %0d expected 2", lock_loss_count); end
        checks++; if (retry_count !== 8'd0) begin errors++; $display("FAIL simul_retry: got %0d expected 0", retry_count); end
        wait_irst(1'b0, 64, n);
        checks++; if (n !== 12) begin errors++; $display("FAIL simul_reseq_fall: got %0d expected 12", n); end
        wait_srst(1'b0, 64, n);
        checks++; if (n !== 24) begin errors++; $display("FAIL simul_reseq_release: got %0d expected 24", n); end
    endtask

    task automatic test_async_reset();
        int n;
        apply_reset();
        release_with_lock();
        bring_up();
        set_force(1'b1);
        wait_irst(1'b1, 16, n);
        set_force(1'b0);
        bring_up();
        checks++; if (retry_count !== 8'd1) begin errors++; $display("FAIL async_pre_retry: got %0d expected 1", retry_count); end
        // Assert reset between clock edges and look before the next edge
        @(posedge sys_clk);
        #4;
        rst = 1'b1;
        #1;
        checks++; if (idelay_rst !== 1'b1) begin errors++; $display("FAIL async_idelay_rst: got %0b expected 1", idelay_rst); end
        checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL async_sys_rst: got %0b expected 1", sys_rst); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL async_ready: got %0b expected 0", ready); end
        checks++; if (retry_count !== 8'd0) begin errors++; $display("FAIL async_retry: got %0d expected 0", retry_count); end
        checks++; if (lock_loss_count !== 8'd0) begin errors++; $display("FAIL async_loss: got %0d expected 0", lock_loss_count); end
        step();
        step();
        rst = 1'b0;
        wait_irst(1'b0, 64, n);
        checks++; if (n !== 14) begin errors++; $display("FAIL async_reseq_fall: got %0d expected 14", n); end
        wait_srst(1'b0, 64, n);
        checks++; if (n !== 24) begin errors++; $display("FAIL async_reseq_release: got %0d expected 24", n); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL async_ready_back: got %0b expected 1", ready); end
    endtask

    initial begin
        rst = 1'b1;
        sys_clk_lock = 1'b0;
        idelay_rdy = 1'b0;
        rdy_en = 1'b1;
        rdy_force_low = 1'b0;
        low_cyc = 0;

        test_reset();
        test_clean_bringup();
        test_glitchy_lock();
        test_rdy_held_low();
        test_rdy_drop();
        test_lock_drop_run();
        test_async_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
